// File: rtl/keccak_round_sequencer_if.sv
// Handshake bundle between the Keccak round sequencer and its step modules.
// The sequencer side is master; the step/test side is slave.
interface keccak_round_sequencer_if #(
   parameter int NUM_STEPS = 5
);
   logic                 start;
   logic [NUM_STEPS-1:0] step_finish;
   logic [NUM_STEPS-1:0] step_start;
   logic [9:0]           file_index;
   logic [4:0]           iteration;
   logic                 busy;
   logic                 done;
   logic                 error;

   modport master (
      input  start,
      input  step_finish,
      output step_start,
      output file_index,
      output iteration,
      output busy,
      output done,
      output error
   );

   modport slave (
      output start,
      output step_finish,
      input  step_start,
      input  file_index,
      input  iteration,
      input  busy,
      input  done,
      input  error
   );
endinterface

// File: rtl/keccak_round_sequencer.sv
// Sequences theta/rho/pi/chi/addRC steps over all rounds of a permutation,
// one step at a time, with a sticky flag for stray step finishes.
module keccak_round_sequencer #(
   parameter int NUM_ROUNDS = 24,
   parameter int NUM_STEPS  = 5,
   parameter int FILE_BASE  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   keccak_round_sequencer_if.master  bus
);

   localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [SW-1:0]        step;
   logic [SW-1:0]        step_nx;
   logic [4:0]           round;
   logic [4:0]           round_nx;
   logic                 error;
   logic                 error_nx;

   logic [NUM_STEPS-1:0] mask;
   logic                 hit;
   logic                 stray;
   logic                 last_step;
   logic                 last_round;

   assign mask       = NUM_STEPS'(1) << step;
   assign hit        = |(bus.step_finish & mask);
   assign stray      = |(bus.step_finish & ~mask);
   assign last_step  = (step == SW'(NUM_STEPS - 1));
   assign last_round = (round == 5'(NUM_ROUNDS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         step  <= '0;
         round <= '0;
         error <= 1'b0;
      end else begin
         state <= state_nx;
         step  <= step_nx;
         round <= round_nx;
         error <= error_nx;
      end
   end

   always_comb begin
      state_nx = state;
      step_nx  = step;
      round_nx = round;
      error_nx = error;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = ISSUE;
               step_nx  = '0;
               round_nx = '0;
               error_nx = 1'b0;
            end
         end
         ISSUE: begin
            state_nx = WAIT;
         end
         WAIT: begin
            // a stray finish is flagged but never blocks the expected one
            if (stray) begin
               error_nx = 1'b1;
            end
            if (hit) begin
               if (!last_step) begin
                  step_nx  = step + SW'(1);
                  state_nx = ISSUE;
               end else if (!last_round) begin
                  step_nx  = '0;
                  round_nx = round + 5'd1;
                  state_nx = ISSUE;
               end else begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
            step_nx  = '0;
            round_nx = '0;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.step_start = (state == ISSUE) ? mask : '0;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.error      = error;
   assign bus.iteration  = round;
   assign bus.file_index = 10'(FILE_BASE
                           + int'(round) * NUM_STEPS
                           + int'(step));

endmodule

// File: doc/keccak_round_sequencer.md
# keccak_round_sequencer

Top-level sequencer for the Keccak permutation datapath. It drives the `start`/`finish` handshake of the per-step modules (theta, rho, pi, chi, add-round-constant). For each of the rounds it supplies the `file_index` and `iteration` each step consumes. It issues one step at a time, waits for that step's `finish`, then advances the step, round and file counters until the full permutation is complete.

## Interface
- `NUM_ROUNDS`, 24: rounds per permutation; 1..31.
- `NUM_STEPS`, 5: step modules per round; step order is theta=0, rho=1, pi=2, chi=3, addRC=4.
- `FILE_BASE`, 0: file index used by step 0 of round 0.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `start`  input  1: begin a permutation; sampled only in IDLE.
- `step_finish`  input  NUM_STEPS: finish flags from the step modules, bit k from step k.
- `step_start`  output  NUM_STEPS: one-hot, one-cycle start pulse to step k.
- `file_index`  output  10: file index for the current step.
- `iteration`  output  5: current round number, 0..NUM_ROUNDS-1.
- `busy`  output  1: high whenever state != IDLE.
- `done`  output  1: one-cycle pulse when the permutation completes.
- `error`  output  1: sticky protocol-error flag.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE. All outputs are Moore, decoded from registered state and counters.
- Registered counters: `step` (0..NUM_STEPS-1) and `round` (0..NUM_ROUNDS-1).
- `iteration` = `round`.
- `file_index` = FILE_BASE + `round`*NUM_STEPS + `step`, 10-bit unsigned, truncated modulo 1024.
- IDLE:
  - `start`=1 → ISSUE; `step` and `round` are 0.
  - `error` clears on the same edge.
  - `start`=0 → stay in IDLE.
- ISSUE:
  - `step_start[step]`=1, all other bits 0.
  - Always → WAIT after exactly one cycle.
  - `step_finish` is ignored in ISSUE.
- WAIT, when `step_finish[step]`=1, advance:
  - If `step` < NUM_STEPS-1: `step`+1 → ISSUE.
  - Else if `round` < NUM_ROUNDS-1: `step`=0, `round`+1 → ISSUE.
  - Else → DONE.
- WAIT, otherwise: hold state. No timeout.
- WAIT error detection: any `step_finish[j]`=1 with j != `step` sets `error`=1.
  - If `step_finish[step]` is also high in the same cycle, advance anyway.
  - `error` stays set until the next accepted `start`.
- DONE:
  - `done`=1 for one cycle, then → IDLE.
  - `step` and `round` return to 0 on that edge.
- `start` asserted outside IDLE is ignored, including during DONE. A new permutation needs `start` high in a later IDLE cycle.
- `step_finish` may be a level or a pulse. It is consumed only in WAIT, so a level held from a previous step has no effect during ISSUE.
- Reset:
  - Asynchronous assertion (`rst`=0) forces IDLE at any point, including mid-permutation.
  - Forces `step`=0, `round`=0, `step_start`=0, `done`=0, `busy`=0, `error`=0.
  - Output values at reset: `file_index`=FILE_BASE, `iteration`=0.
  - No partial state survives. After release, the block waits for `start`.

## Timing
- `start` sampled high at edge E0 → `step_start[0]`=1 during the cycle E0→E1, with `busy`=1 from E0.
- Per step:
  - ISSUE takes 1 cycle, then WAIT takes ≥1 cycle.
  - If finish is high in the first WAIT cycle, the next ISSUE follows immediately: 2 cycles per step.
- `file_index` and `iteration` update on the edge that leaves WAIT. They are stable throughout the ISSUE and WAIT cycles of the step they describe.
- Minimum permutation length, start edge to `done` cycle: 2*NUM_ROUNDS*NUM_STEPS cycles; `done` occupies the next cycle.
  - Defaults: 240 cycles to `done`, 241 until IDLE.
- `busy` falls on the edge leaving DONE.

## Test plan
- Default parameters, step model returns finish 1 cycle after start:
  - Exactly 120 `step_start` pulses in order bit0..bit4, repeated.
  - `iteration` 0..23, `file_index` 0..119.
  - `done` pulses once at cycle 241 after `start`; `error`=0.
- Random finish latency 1..20 cycles per step:
  - Same pulse order and indices; no pulse issued while a step is pending.
  - `done` exactly once.
- `rst`=0 asserted during round 7, step 2:
  - All outputs return immediately to reset values.
  - A new `start` restarts at `file_index`=0, `iteration`=0.
- `step_finish[3]` pulsed while waiting on step 1:
  - `error`=1, sequencing continues unchanged.
  - `error` is still 1 after `done`; clears on the next `start`.
- `start` held high continuously:
  - A second permutation begins only after DONE→IDLE.
  - No `start` sampled during busy; `file_index` restarts at FILE_BASE.
- FILE_BASE=100, NUM_ROUNDS=2:
  - `file_index` 100..109, `iteration` 0..1.
  - `done` at cycle 21 with 1-cycle finish latency.
